// File: rtl/tmds_decode.sv
// tmds_decode: one TMDS receive lane, word alignment via bitslip plus decode.
// Define TMDS_GUARD_EN to recognise the video guard band (adds is_guard port).
module tmds_decode #(
  parameter int CHANNEL        = 0,
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_WINDOW  = 1024,
  parameter int SLIP_SETTLE    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] tmds,
  output logic       bitslip,
  output logic       locked,
  output logic [7:0] data,
  output logic [1:0] control,
  output logic       in_image,
`ifdef TMDS_GUARD_EN
  output logic       is_guard,
`endif
  output logic       is_control
);

  localparam int TW = $clog2(LOCK_TOKENS + 2);
  localparam int WW = $clog2(SEARCH_WINDOW + 2);
  localparam int SW = $clog2(SLIP_SETTLE + 2);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [TW-1:0] TOK_LAST = TW'(LOCK_TOKENS - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(SEARCH_WINDOW - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SLIP_SETTLE - 1);
  localparam logic [OW-1:0] TO_LAST  = OW'(TIMEOUT_CYCLES - 1);

  localparam logic [9:0] GUARD =
    (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

`ifdef TMDS_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    SETTLE,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [9:0]    sym_q;
  logic [TW-1:0] tok_cnt_q, tok_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic [OW-1:0] to_cnt_q, to_cnt_d;

  logic       bitslip_q, bitslip_d;
  logic       locked_q, locked_d;
  logic [7:0] data_q, data_d;
  logic [1:0] control_q, control_d;
  logic       in_image_q, in_image_d;
  logic       is_control_q, is_control_d;
  logic       is_guard_q, is_guard_d;

  logic       is_tok;
  logic [1:0] tok_val;
  logic       is_grd;
  logic [7:0] pre;
  logic [7:0] dec;
  logic       lock_nx;

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    unique case (sym_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  assign is_grd = GUARD_EN && (sym_q == GUARD);

  // Undo the transmit-side XOR/XNOR chain and optional inversion.
  assign pre = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];

  always_comb begin
    dec    = 8'h00;
    dec[0] = pre[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_q[8] ? (pre[i] ^ pre[i-1])
                        : ~(pre[i] ^ pre[i-1]);
    end
  end

  always_comb begin
    state_d   = state_q;
    tok_cnt_d = '0;
    win_cnt_d = '0;
    set_cnt_d = '0;
    to_cnt_d  = '0;
    unique case (state_q)
      SEARCH: begin
        if (is_tok && tok_cnt_q >= TOK_LAST) begin
          state_d = LOCKED;
        end else if (win_cnt_q >= WIN_LAST) begin
          state_d = SLIP;
        end else begin
          tok_cnt_d = is_tok ? tok_cnt_q + TW'(1) : '0;
          win_cnt_d = win_cnt_q + WW'(1);
        end
      end
      SLIP: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (set_cnt_q >= SET_LAST) begin
          state_d = SEARCH;
        end else begin
          set_cnt_d = set_cnt_q + SW'(1);
        end
      end
      LOCKED: begin
        // A token on the final timeout cycle still rescues the lock.
        if (is_tok) begin
          to_cnt_d = '0;
        end else if (to_cnt_q >= TO_LAST) begin
          state_d = SEARCH;
        end else begin
          to_cnt_d = to_cnt_q + OW'(1);
        end
      end
    endcase
  end

  assign lock_nx = (state_d == LOCKED);

  always_comb begin
    bitslip_d    = (state_d == SLIP);
    locked_d     = lock_nx;
    is_control_d = is_tok;
    in_image_d   = lock_nx && !is_tok && !is_grd;
    is_guard_d   = lock_nx && is_grd;
    data_d       = in_image_d ? dec : 8'h00;
    control_d    = 2'b00;
    if (lock_nx) begin
      control_d = is_tok ? tok_val : control_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_q        <= '0;
      state_q      <= SEARCH;
      tok_cnt_q    <= '0;
      win_cnt_q    <= '0;
      set_cnt_q    <= '0;
      to_cnt_q     <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      data_q       <= 8'h00;
      control_q    <= 2'b00;
      in_image_q   <= 1'b0;
      is_control_q <= 1'b0;
      is_guard_q   <= 1'b0;
    end else begin
      sym_q        <= tmds;
      state_q      <= state_d;
      tok_cnt_q    <= tok_cnt_d;
      win_cnt_q    <= win_cnt_d;
      set_cnt_q    <= set_cnt_d;
      to_cnt_q     <= to_cnt_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      data_q       <= data_d;
      control_q    <= control_d;
      in_image_q   <= in_image_d;
      is_control_q <= is_control_d;
      is_guard_q   <= is_guard_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign data       = data_q;
  assign control    = control_q;
  assign in_image   = in_image_q;
  assign is_control = is_control_q;

`ifdef TMDS_GUARD_EN
  assign is_guard = is_guard_q;
`else
  logic unused_guard;
  assign unused_guard = is_guard_q;
`endif

endmodule

// File: tb/tb_tmds_decode.sv
// tb_tmds_decode: self-checking bench for the tmds_decode lane decoder.
// Vector table plus scoreboard queue, and directed alignment/timeout runs.
module tb_tmds_decode;

  localparam int W = 1024;
  localparam int S = 16;
  localparam int T = 4096;
  localparam int L = 8;
  localparam logic [9:0] TK0 = 10'b1101010100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] tmds = 10'h000;
  logic       bitslip, locked, in_image, is_control, is_guard;
  logic [7:0] data;
  logic [1:0] control;

  int ntests = 0;
  int nfail  = 0;
  int tagc   = 0;

  typedef struct packed {
    logic        chk;
    logic [15:0] tag;
    logic [7:0]  d;
    logic [1:0]  c;
    logic        img;
    logic        ctl;
    logic        grd;
    logic        lck;
  } exp_t;

  typedef struct packed {
    logic [9:0] sym;
    logic [7:0] d;
    logic [1:0] c;
    logic       img;
    logic       ctl;
    logic       grd;
  } vec_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  tmds_decode #(
    .CHANNEL(1),
    .LOCK_TOKENS(L),
    .SEARCH_WINDOW(W),
    .SLIP_SETTLE(S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tmds(tmds),
    .bitslip(bitslip),
    .locked(locked),
    .data(data),
    .control(control),
    .in_image(in_image),
`ifdef TMDS_GUARD_EN
    .is_guard(is_guard),
`endif
    .is_control(is_control)
  );

`ifndef TMDS_GUARD_EN
  assign is_guard = 1'b0;
`endif

  function automatic vec_t mk(input logic [9:0] s, input logic [7:0] d,
                              input logic [1:0] c, input logic img,
                              input logic ctl, input logic grd);
    vec_t v;
    v.sym = s;
    v.d   = d;
    v.c   = c;
    v.img = img;
    v.ctl = ctl;
    v.grd = grd;
    return v;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int off);
    logic [19:0] t;
    t = {w, w} >> off;
    return t[9:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Drive one symbol; compare the record pushed two symbols earlier.
  task automatic step(input logic [9:0] w, input logic chk,
                      input logic [7:0] d, input logic [1:0] c,
                      input logic img, input logic ctl,
                      input logic grd, input logic lck);
    exp_t x;
    exp_t e;
    @(negedge clk);
    if (sbq.size() >= 2) begin
      x = sbq.pop_front();
      if (x.chk) begin
        ntests++;
        if ({data, control, in_image, is_control, is_guard, locked} !==
            {x.d, x.c, x.img, x.ctl, x.grd, x.lck}) begin
          nfail++;
          $display("FAIL sb%0d: got d=%h c=%b img=%b ctl=%b grd=%b lck=%b want d=%h c=%b img=%b ctl=%b grd=%b lck=%b",
                   x.tag, data, control, in_image, is_control, is_guard,
                   locked, x.d, x.c, x.img, x.ctl, x.grd, x.lck);
        end
      end
    end
    tmds = w;
    e.chk = chk;
    e.tag = 16'(tagc);
    e.d   = d;
    e.c   = c;
    e.img = img;
    e.ctl = ctl;
    e.grd = grd;
    e.lck = lck;
    tagc++;
    sbq.push_back(e);
  endtask

  initial begin
    vec_t vt[15];
    int   off;
    int   np;
    int   last;
    int   cnt;
    bit   done;
    bit   seen;

    vt[0]  = mk(10'h100, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    vt[1]  = mk(10'h2FF, 8'hFE, 2'b00, 1'b1, 1'b0, 1'b0);
    vt[2]  = mk(10'h0AB, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0);
    vt[3]  = mk(10'h1FF, 8'h01, 2'b01, 1'b1, 1'b0, 1'b0);
    vt[4]  = mk(10'h0FF, 8'hFF, 2'b01, 1'b1, 1'b0, 1'b0);
    vt[5]  = mk(10'h154, 8'h00, 2'b10, 1'b0, 1'b1, 1'b0);
    vt[6]  = mk(10'h155, 8'hFF, 2'b10, 1'b1, 1'b0, 1'b0);
    vt[7]  = mk(10'h2A5, 8'h10, 2'b10, 1'b1, 1'b0, 1'b0);
    vt[8]  = mk(10'h2AB, 8'h00, 2'b11, 1'b0, 1'b1, 1'b0);
    vt[9]  = mk(10'h300, 8'h01, 2'b11, 1'b1, 1'b0, 1'b0);
    vt[10] = mk(10'h10F, 8'h11, 2'b11, 1'b1, 1'b0, 1'b0);
`ifdef TMDS_GUARD_EN
    vt[11] = mk(10'h133, 8'h00, 2'b11, 1'b0, 1'b0, 1'b1);
`else
    vt[11] = mk(10'h133, 8'h55, 2'b11, 1'b1, 1'b0, 1'b0);
`endif
    vt[12] = mk(TK0,     8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    vt[13] = mk(10'h2CC, 8'hAB, 2'b00, 1'b1, 1'b0, 1'b0);
    vt[14] = mk(TK0,     8'h00, 2'b00, 1'b0, 1'b1, 1'b0);

    // Outputs stay quiet throughout reset.
    repeat (4) begin
      @(negedge clk);
      check("reset_out",
            32'({bitslip, locked, data, control, in_image, is_control,
                 is_guard}), 32'h0);
    end
    reset_n = 1'b1;

    repeat (3) step(10'h000, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L - 1; i++) begin
      step(TK0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(TK0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 15; i++) begin
      step(vt[i].sym, 1'b1, vt[i].d, vt[i].c, vt[i].img, vt[i].ctl,
           vt[i].grd, 1'b1);
    end

    // A token on the last timeout cycle keeps lock; a data symbol drops it.
    repeat (T - 1) step(10'h100, 1'b1, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(TK0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (T - 1) step(10'h100, 1'b1, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(10'h100, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(10'h100, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(10'h000, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(10'h000, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    sbq.delete();

    // Stream misaligned by 3 bits; each bitslip rotates the model by one.
    reset_n = 1'b0;
    off = 3;
    np = 0;
    last = 0;
    done = 1'b0;
    tmds = rot(TK0, off);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (locked) done = 1'b1;
      if (bitslip) begin
        if (np > 0) check("slip_gap", 32'(c - last), 32'(W + S + 1));
        np++;
        last = c;
        off = (off == 0) ? 9 : off - 1;
      end
      tmds = rot(TK0, off);
    end
    check("slip_count", 32'(np), 32'd3);
    check("rot_lock", 32'(locked), 32'd1);
    repeat (20) begin
      @(negedge clk);
      check("locked_no_slip", 32'({bitslip, locked}), 32'd1);
      tmds = TK0;
    end

    // Reset while bitslip is high, then the window restarts from zero.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tmds = 10'h000;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (bitslip) seen = 1'b1;
    end
    check("slip_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_drop", 32'({bitslip, locked}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    seen = 1'b0;
    for (int c = 1; c <= 2000 && !seen; c++) begin
      @(negedge clk);
      if (bitslip) begin
        seen = 1'b1;
        cnt = c;
      end
    end
    check("restart_window", 32'(cnt), 32'(W));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
